home_inventory_sample_framer: RTL and testbench
===============================================

HOME_INVENTORY_SAMPLE_FRAMER -- requirements
Module: home_inventory_sample_framer

Interface
REQ-001 Parameter TS_DIV, 1, clock cycles per timestamp tick; legal range 1..65535.
REQ-002 Parameter TIMEOUT_CYCLES, 1024, idle cycles allowed inside a partial frame before it is dropped; legal range 2..65535.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  upstream ADC word valid.
REQ-006 in_ready  output  1  framer accepts a word when in_valid && in_ready.
REQ-007 in_ch  input  3  channel index of the offered word.
REQ-008 in_data  input  32  sample value of the offered word.
REQ-009 err_clear  input  1  synchronous clear of frames_dropped and frame_err.
REQ-010 sample_valid  output  1  one-cycle pulse: a complete frame is presented.
REQ-011 ts_now  output  32  timestamp of the presented frame; held between pulses.
REQ-012 sample_ch0..sample_ch7  output  32 each  channel samples of the presented frame; held between pulses.
REQ-013 frames_dropped  output  16  saturating count of discarded partial frames.
REQ-014 frame_err  output  1  sticky flag, set on any frame drop.

Function
REQ-015 Timestamp counter: 32-bit, increments by 1 once every TS_DIV clocks via a prescaler; wraps 0xFFFF_FFFF->0; free-running regardless of frame state.
REQ-016 States: IDLE (no words held), FILL (partial frame, 8-bit received mask nonzero), EMIT (one cycle, frame output).
REQ-017 in_ready is 1 in IDLE and FILL, 0 in EMIT.
REQ-018 Accepted word in IDLE: store in_data in staging slot in_ch, set mask bit, capture current timestamp as frame timestamp, go FILL.
REQ-019 Accepted word in FILL with mask bit for in_ch clear: store, set mask bit; mask becomes 0xFF -> go EMIT next cycle.
REQ-020 Accepted word whose in_ch bit is already set (duplicate): discard partial frame as a drop (REQ-023), start a new frame with this word as its first word (mask = that bit only, new timestamp captured), remain FILL.
REQ-021 EMIT: sample_valid=1 for exactly that cycle; sample_ch0..7 and ts_now update in the same cycle the pulse is high; mask clears; return IDLE next cycle. Latency: last word accepted at cycle N -> sample_valid at N+1; next word acceptable at N+2.
REQ-022 Outputs sample_ch*/ts_now change only on EMIT; partial or dropped frames never reach them.
REQ-023 Drop: frames_dropped increments saturating at 0xFFFF; frame_err set.
REQ-024 err_clear: frames_dropped<=0, frame_err<=0; if a drop occurs the same cycle, result is frames_dropped=1, frame_err=1.
REQ-025 Word order within a frame is unconstrained; any permutation of 8 distinct channels completes a frame.

Reset
REQ-026 rst_n low asynchronously forces: state IDLE, mask 0, prescaler 0, timestamp 0, staging slots 0, sample_valid 0, ts_now 0, sample_ch0..7 0, frames_dropped 0, frame_err 0, timeout counter 0.
REQ-027 Reset asserted mid-frame discards the partial frame without counting a drop; in_ready is 1 in the first cycle after rst_n deassertion.

Configuration
REQ-028 Macro HOME_INVENTORY_FRAMER_TIMEOUT_EN defined: a 16-bit idle counter runs in FILL, reset to 0 on every accepted word; on reaching TIMEOUT_CYCLES-1 with no word accepted that cycle, the partial frame is dropped (REQ-023) and state returns IDLE; word acceptance in the same cycle wins (no drop).
REQ-029 Macro undefined: no idle counter is built; a partial frame is held indefinitely; drops arise only from duplicates.

Verification
REQ-030 TS_DIV=4: words ch0..ch7 data 0x100+ch, back-to-back from timestamp 3 -> one sample_valid pulse one cycle after ch7 accepted, sample_chK=0x100+K, ts_now=3, in_ready=0 during pulse cycle.
REQ-031 Order ch7,ch2,ch0,ch5,ch1,ch6,ch4,ch3 with gaps of 5 idle cycles -> single frame, correct slot mapping, frames_dropped=0.
REQ-032 ch0,ch1,ch1(data 0xBEEF),ch0,ch2..ch7 -> frames_dropped=1, frame_err=1, frame emitted with sample_ch1=0xBEEF, ts_now = timestamp at second ch1 word.
REQ-033 TIMEOUT_EN defined, TIMEOUT_CYCLES=16: ch0..ch3 then silence -> drop after 16 idle cycles, state IDLE, no sample_valid; with macro undefined -> no drop after 1000 cycles, ch4..ch7 then complete the frame.
REQ-034 Force timestamp counter near 0xFFFF_FFFF (TS_DIV=1): frames straddling wrap -> ts_now 0xFFFF_FFFE then 0x0000_000x; 65536 duplicate drops -> frames_dropped saturates 0xFFFF; err_clear simultaneous with drop -> 1.
REQ-035 rst_n pulsed low after ch0..ch5 accepted -> all outputs 0 immediately, no drop counted; fresh ch0..ch7 produce a normal frame.

Source files
------------

// File: rtl/home_inventory_sample_framer_if.sv
// Upstream ADC word handshake into the sample framer.
//   in_valid : word offered
//   in_ready : framer can take a word this cycle
//   in_ch    : channel index 0..7 of the offered word
//   in_data  : sample value of the offered word
// master = ADC side (drives the word), slave = framer.
interface home_inventory_sample_framer_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_ch;
  logic [31:0] in_data;

  modport master (output in_valid, output in_ch, output in_data, input in_ready);
  modport slave  (input in_valid, input in_ch, input in_data, output in_ready);
endinterface

// File: rtl/home_inventory_sample_framer.sv
// Collects one 32-bit word per channel (8 channels, any order) into a frame
// stamped with the timestamp of its first word, then presents the frame for
// one cycle. A repeated channel inside a partial frame drops the partial frame
// and restarts with the repeated word.
//
// Optional feature: define HOME_INVENTORY_FRAMER_TIMEOUT_EN to drop a partial
// frame that sees TIMEOUT_CYCLES idle cycles with no accepted word.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_if (slave)     in_valid/in_ready/in_ch/in_data word handshake
//   err_clear         synchronous clear of frames_dropped and frame_err
//   sample_valid      one-cycle pulse with a complete frame
//   ts_now            timestamp of the presented frame (held)
//   sample_ch0..7     channel samples of the presented frame (held)
//   frames_dropped    saturating count of discarded partial frames
//   frame_err         sticky drop flag
//
// state | meaning
// IDLE  | no words held
// FILL  | partial frame, received mask nonzero
// EMIT  | frame presented this cycle, input stalled
module home_inventory_sample_framer #(
  parameter int unsigned TS_DIV         = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  home_inventory_sample_framer_if.slave in_if,
  input  logic        err_clear,
  output logic        sample_valid,
  output logic [31:0] ts_now,
  output logic [31:0] sample_ch0,
  output logic [31:0] sample_ch1,
  output logic [31:0] sample_ch2,
  output logic [31:0] sample_ch3,
  output logic [31:0] sample_ch4,
  output logic [31:0] sample_ch5,
  output logic [31:0] sample_ch6,
  output logic [31:0] sample_ch7,
  output logic [15:0] frames_dropped,
  output logic        frame_err
);
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, EMIT = 2'd2} state_t;

  localparam logic [15:0] PRESC_LAST = 16'(TS_DIV - 1);

  state_t      state;
  logic [15:0] presc;
  logic [31:0] ts_cnt;
  logic [7:0]  mask;
  logic [31:0] stage [8];
  logic [31:0] sample_q [8];
  logic [31:0] frame_ts;
  logic        ready;
  logic        accept;
  logic        dup;
  logic        timeout_hit;
  logic        drop;
  logic [7:0]  ch_bit;

  assign ready          = (state != EMIT);
  assign in_if.in_ready = ready;
  assign accept         = in_if.in_valid && ready;
  assign ch_bit         = 8'b1 << in_if.in_ch;
  assign dup            = accept && (state == FILL) && mask[in_if.in_ch];
  assign drop           = dup || timeout_hit;

`ifdef HOME_INVENTORY_FRAMER_TIMEOUT_EN
  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] idle_cnt;

  // An accepted word in the limit cycle wins over the timeout.
  assign timeout_hit = (state == FILL) && !accept && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if ((state != FILL) || accept || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end
`else
  // Timeout length has no effect without the idle counter.
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // Free-running timestamp, independent of frame state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc  <= '0;
      ts_cnt <= '0;
    end else if (presc == PRESC_LAST) begin
      presc  <= '0;
      ts_cnt <= ts_cnt + 32'd1;
    end else begin
      presc  <= presc + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mask         <= '0;
      frame_ts     <= '0;
      sample_valid <= 1'b0;
      ts_now       <= '0;
      for (int k = 0; k < 8; k++) begin
        stage[k]    <= '0;
        sample_q[k] <= '0;
      end
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            stage[in_if.in_ch] <= in_if.in_data;
            mask               <= ch_bit;
            frame_ts           <= ts_cnt;
            state              <= FILL;
          end
        end
        FILL: begin
          if (accept) begin
            stage[in_if.in_ch] <= in_if.in_data;
            if (dup) begin
              mask     <= ch_bit;
              frame_ts <= ts_cnt;
            end else if ((mask | ch_bit) == 8'hFF) begin
              // Publish straight from staging plus the word arriving now.
              for (int k = 0; k < 8; k++) begin
                sample_q[k] <= (3'(k) == in_if.in_ch) ? in_if.in_data : stage[k];
              end
              ts_now       <= frame_ts;
              sample_valid <= 1'b1;
              mask         <= '0;
              state        <= EMIT;
            end else begin
              mask <= mask | ch_bit;
            end
          end else if (timeout_hit) begin
            mask  <= '0;
            state <= IDLE;
          end
        end
        EMIT: begin
          state <= IDLE;
        end
        default: begin
          mask  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // A clear coinciding with a drop leaves exactly that one drop recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_dropped <= '0;
      frame_err      <= 1'b0;
    end else if (err_clear) begin
      frames_dropped <= {15'd0, drop};
      frame_err      <= drop;
    end else if (drop) begin
      if (frames_dropped != 16'hFFFF) frames_dropped <= frames_dropped + 16'd1;
      frame_err <= 1'b1;
    end
  end

  assign sample_ch0 = sample_q[0];
  assign sample_ch1 = sample_q[1];
  assign sample_ch2 = sample_q[2];
  assign sample_ch3 = sample_q[3];
  assign sample_ch4 = sample_q[4];
  assign sample_ch5 = sample_q[5];
  assign sample_ch6 = sample_q[6];
  assign sample_ch7 = sample_q[7];
endmodule

// File: tb/tb_home_inventory_sample_framer.sv
// Self-checking bench for home_inventory_sample_framer. A transaction-level
// model (per-channel presence flags, stored values, drop count, timestamp as
// cycles/TS_DIV) predicts every output each cycle; directed sequences and a
// vector table add explicit expected constants for the corner cases.
module tb_home_inventory_sample_framer;
  localparam int TS_DIV         = 4;
  localparam int TIMEOUT_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        err_clear = 1'b0;
  logic        sample_valid;
  logic [31:0] ts_now;
  logic [31:0] s_out [8];
  logic [15:0] frames_dropped;
  logic        frame_err;

  home_inventory_sample_framer_if bus ();

  home_inventory_sample_framer #(.TS_DIV(TS_DIV), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .in_if(bus.slave), .err_clear(err_clear),
    .sample_valid(sample_valid), .ts_now(ts_now),
    .sample_ch0(s_out[0]), .sample_ch1(s_out[1]), .sample_ch2(s_out[2]), .sample_ch3(s_out[3]),
    .sample_ch4(s_out[4]), .sample_ch5(s_out[5]), .sample_ch6(s_out[6]), .sample_ch7(s_out[7]),
    .frames_dropped(frames_dropped), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  longint unsigned cyc;
  logic [31:0] ts_base;
  bit          have [8];
  logic [31:0] vals [8];
  logic [31:0] fts;
  bit          emit_m;
  logic [31:0] exp_s [8];
  logic [31:0] exp_ts;
  int unsigned drops_m;
  bit          err_m;
  int          idle_m;

  typedef struct {
    bit          v;
    int          ch;
    logic [31:0] d;
    bit          exp_ready;
    bit          exp_sv;
    logic [15:0] exp_drops;
  } vec_t;
  vec_t tbl [11];

  function automatic logic [31:0] ts_m();
    return ts_base + 32'(cyc / longint'(TS_DIV));
  endfunction

  function automatic int count_have();
    int c = 0;
    for (int k = 0; k < 8; k++) if (have[k]) c++;
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc = 0; ts_base = '0; fts = '0; emit_m = 0; exp_ts = '0;
    drops_m = 0; err_m = 0; idle_m = 0;
    for (int k = 0; k < 8; k++) begin have[k] = 0; vals[k] = '0; exp_s[k] = '0; end
  endtask

  task automatic model_step();
    bit acc, drop;
    int ch;
    logic [31:0] ts_cur;
    ts_cur = ts_m();
    acc  = bus.in_valid && !emit_m;
    ch   = int'(bus.in_ch);
    drop = 0;
    emit_m = 0;
    if (acc) begin
      idle_m = 0;
      if (have[ch]) begin
        drop = 1;
        for (int k = 0; k < 8; k++) have[k] = 0;
      end
      if (count_have() == 0) fts = ts_cur;
      have[ch] = 1;
      vals[ch] = bus.in_data;
      if (count_have() == 8) begin
        emit_m = 1;
        exp_ts = fts;
        for (int k = 0; k < 8; k++) begin exp_s[k] = vals[k]; have[k] = 0; end
      end
    end else if (count_have() != 0) begin
`ifdef HOME_INVENTORY_FRAMER_TIMEOUT_EN
      if (idle_m == TIMEOUT_CYCLES - 1) begin
        drop = 1;
        idle_m = 0;
        for (int k = 0; k < 8; k++) have[k] = 0;
      end else begin
        idle_m++;
      end
`endif
    end
    if (err_clear) begin
      drops_m = drop ? 1 : 0;
      err_m   = drop;
    end else if (drop) begin
      if (drops_m < 16'hFFFF) drops_m++;
      err_m = 1;
    end
    cyc++;
  endtask

  task automatic check_all();
    chk("sample_valid", {31'd0, sample_valid}, {31'd0, emit_m});
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, !emit_m});
    chk("ts_now", ts_now, exp_ts);
    for (int k = 0; k < 8; k++) chk($sformatf("sample_ch%0d", k), s_out[k], exp_s[k]);
    chk("frames_dropped", {16'd0, frames_dropped}, drops_m);
    chk("frame_err", {31'd0, frame_err}, {31'd0, err_m});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic send(input int ch, input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_ch    = 3'(ch);
    bus.in_data  = d;
    cycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    chk("ready_after_reset", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    int order [8];
    logic [31:0] ts_dup;
    int missing [$];
    int ch;

    tbl[0]  = '{1'b1, 0, 32'h200,  1'b1, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 1, 32'h201,  1'b1, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 1, 32'hBEEF, 1'b1, 1'b0, 16'd1};
    tbl[3]  = '{1'b1, 0, 32'h300,  1'b1, 1'b0, 16'd1};
    tbl[4]  = '{1'b1, 2, 32'h302,  1'b1, 1'b0, 16'd1};
    tbl[5]  = '{1'b1, 3, 32'h303,  1'b1, 1'b0, 16'd1};
    tbl[6]  = '{1'b1, 4, 32'h304,  1'b1, 1'b0, 16'd1};
    tbl[7]  = '{1'b1, 5, 32'h305,  1'b1, 1'b0, 16'd1};
    tbl[8]  = '{1'b1, 6, 32'h306,  1'b1, 1'b0, 16'd1};
    tbl[9]  = '{1'b1, 7, 32'h307,  1'b1, 1'b1, 16'd1};
    tbl[10] = '{1'b0, 0, 32'h0,    1'b0, 1'b0, 16'd1};
    order = '{7, 2, 0, 5, 1, 6, 4, 3};

    bus.in_valid = 1'b0;
    bus.in_ch    = 3'd0;
    bus.in_data  = '0;
    model_reset();
    do_reset();

    // ch0..ch7 back to back starting at timestamp 3
    for (int i = 0; i < 64 && ts_m() != 32'd3; i++) cycle();
    chk("start_ts", ts_m(), 32'd3);
    for (int k = 0; k < 8; k++) send(k, 32'h100 + 32'(k));
    chk("pulse_valid", {31'd0, sample_valid}, 32'd1);
    chk("pulse_ts", ts_now, 32'd3);
    chk("pulse_ready", {31'd0, bus.in_ready}, 32'd0);
    for (int k = 0; k < 8; k++) chk("pulse_slot", s_out[k], 32'h100 + 32'(k));
    idle(2);

    // permuted order with gaps
    for (int i = 0; i < 8; i++) begin
      send(order[i], 32'h400 + 32'(order[i]));
      if (i < 7) idle(5);
    end
    chk("perm_valid", {31'd0, sample_valid}, 32'd1);
    for (int k = 0; k < 8; k++) chk("perm_slot", s_out[k], 32'h400 + 32'(k));
    chk("perm_drops", {16'd0, frames_dropped}, 32'd0);
    idle(2);

    // duplicate restarts the frame
    ts_dup = '0;
    for (int i = 0; i < 11; i++) begin
      bus.in_valid = tbl[i].v;
      bus.in_ch    = 3'(tbl[i].ch);
      bus.in_data  = tbl[i].d;
      if (i == 2) ts_dup = ts_m();
      chk("vec_ready", {31'd0, bus.in_ready}, {31'd0, tbl[i].exp_ready});
      cycle();
      chk("vec_valid", {31'd0, sample_valid}, {31'd0, tbl[i].exp_sv});
      chk("vec_drops", {16'd0, frames_dropped}, {16'd0, tbl[i].exp_drops});
    end
    bus.in_valid = 1'b0;
    chk("dup_ch1", s_out[1], 32'hBEEF);
    chk("dup_ch0", s_out[0], 32'h300);
    chk("dup_ts", ts_now, ts_dup);
    chk("dup_err", {31'd0, frame_err}, 32'd1);
    idle(2);

    // partial frame followed by silence
    for (int k = 0; k < 4; k++) send(k, 32'h500 + 32'(k));
`ifdef HOME_INVENTORY_FRAMER_TIMEOUT_EN
    idle(TIMEOUT_CYCLES - 1);
    chk("timeout_before", {16'd0, frames_dropped}, 32'd1);
    idle(1);
    chk("timeout_drop", {16'd0, frames_dropped}, 32'd2);
    idle(4);
`else
    idle(1000);
    chk("hold_drops", {16'd0, frames_dropped}, 32'd1);
    for (int k = 4; k < 8; k++) send(k, 32'h500 + 32'(k));
    chk("hold_valid", {31'd0, sample_valid}, 32'd1);
    for (int k = 0; k < 8; k++) chk("hold_slot", s_out[k], 32'h500 + 32'(k));
    idle(2);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      missing.delete();
      for (int k = 0; k < 8; k++) if (!have[k]) missing.push_back(k);
      if ($urandom_range(0, 19) == 0 || missing.size() == 0) ch = int'($urandom_range(0, 7));
      else ch = missing[$urandom_range(0, missing.size() - 1)];
      bus.in_valid = ($urandom_range(0, 9) < 7);
      bus.in_ch    = 3'(ch);
      bus.in_data  = $urandom;
      err_clear    = ($urandom_range(0, 49) == 0);
      cycle();
    end
    bus.in_valid = 1'b0;
    err_clear    = 1'b0;

    // timestamp wrap
    do_reset();
    force dut.ts_cnt = 32'hFFFF_FFFE;
    ts_base = 32'hFFFF_FFFE - 32'(cyc / longint'(TS_DIV));
    #1;
    release dut.ts_cnt;
    for (int k = 0; k < 8; k++) send(k, 32'h600 + 32'(k));
    chk("wrap_ts_hi", ts_now, 32'hFFFF_FFFE);
    idle(1);
    for (int k = 0; k < 8; k++) send(k, 32'h700 + 32'(k));
    chk("wrap_valid", {31'd0, sample_valid}, 32'd1);
    chk("wrap_ts_lo", {31'd0, ts_now < 32'd16}, 32'd1);
    idle(1);

    // drop counter saturation and clear
    for (int i = 0; i < 65537; i++) send(0, $urandom);
    chk("sat_drops", {16'd0, frames_dropped}, 32'h0000_FFFF);
    err_clear = 1'b1;
    send(0, 32'h1);
    chk("clr_drop_cnt", {16'd0, frames_dropped}, 32'd1);
    chk("clr_drop_err", {31'd0, frame_err}, 32'd1);
    idle(1);
    err_clear = 1'b0;
    chk("clr_cnt", {16'd0, frames_dropped}, 32'd0);
    chk("clr_err", {31'd0, frame_err}, 32'd0);

    // reset in the middle of a frame
    send(0, 32'h800);
    send(0, 32'h800);
    for (int k = 1; k < 6; k++) send(k, 32'h800 + 32'(k));
    chk("pre_rst_drops", {16'd0, frames_dropped}, 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", {31'd0, sample_valid}, 32'd0);
    chk("rst_ts", ts_now, 32'd0);
    for (int k = 0; k < 8; k++) chk("rst_slot", s_out[k], 32'd0);
    chk("rst_drops", {16'd0, frames_dropped}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int k = 0; k < 8; k++) send(k, 32'h900 + 32'(k));
    chk("post_rst_valid", {31'd0, sample_valid}, 32'd1);
    for (int k = 0; k < 8; k++) chk("post_rst_slot", s_out[k], 32'h900 + 32'(k));
    chk("post_rst_drops", {16'd0, frames_dropped}, 32'd0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
